// File: rtl/move_controller_if.sv
// Command/position bundle between the game-board control and move_controller.
// master drives commands and the win flag; slave is the controller.
interface move_controller_if #(
  parameter int COUNT_WIDTH = 14
);
  logic                   load;
  logic [4:0]             initialBlank;
  logic                   dirValid;
  logic [1:0]             dir;
  logic                   ifWin;
  logic [4:0]             moveFrom;
  logic [4:0]             moveTo;
  logic                   moveValid;
  logic                   reject;
  logic                   ready;
  logic                   won;
  logic [COUNT_WIDTH-1:0] moveCount;

  modport master (
    output load, initialBlank, dirValid, dir, ifWin,
    input  moveFrom, moveTo, moveValid, reject, ready, won, moveCount
  );

  modport slave (
    input  load, initialBlank, dirValid, dir, ifWin,
    output moveFrom, moveTo, moveValid, reject, ready, won, moveCount
  );
endinterface

// File: rtl/move_controller.sv
// Turns direction strobes into registered moveFrom/moveTo pairs and tracks the blank tile.
// One move per 3 cycles (IDLE accept, MOVE, SETTLE); commands outside IDLE are dropped.
module move_controller #(
  parameter int COUNT_WIDTH = 14,
  parameter int MAX_MOVES   = 9999,
  parameter int RESET_BLANK = 16
) (
  input  logic              clk,
  input  logic              resetn,
  move_controller_if.slave  bus_io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_WON
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = COUNT_WIDTH'(MAX_MOVES);
  localparam logic [4:0]             BLANK_RST = 5'(RESET_BLANK);

  state_e                 state_q, state_d;
  logic [4:0]             blank_q, blank_d;
  logic [4:0]             from_q,  from_d;
  logic [4:0]             to_q,    to_d;
  logic                   vld_q,   vld_d;
  logic                   rej_q,   rej_d;
  logic [COUNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic [3:0] pos_m1;
  logic [1:0] row;
  logic [1:0] col;
  logic       legal;
  logic [4:0] nbr;
  logic [4:0] load_blank;

  // Blank 16 wraps to 15 in 4 bits, which is still row 3 / col 3.
  always_comb begin
    pos_m1 = blank_q[3:0] - 4'd1;
    row    = pos_m1[3:2];
    col    = pos_m1[1:0];
    legal  = 1'b0;
    nbr    = blank_q;
    case (bus_io.dir)
      DIR_UP: begin
        legal = (row != 2'd3);
        nbr   = blank_q + 5'd4;
      end
      DIR_DOWN: begin
        legal = (row != 2'd0);
        nbr   = blank_q - 5'd4;
      end
      DIR_LEFT: begin
        legal = (col != 2'd3);
        nbr   = blank_q + 5'd1;
      end
      DIR_RIGHT: begin
        legal = (col != 2'd0);
        nbr   = blank_q - 5'd1;
      end
      default: begin
        legal = 1'b0;
        nbr   = blank_q;
      end
    endcase
  end

  always_comb begin
    load_blank = bus_io.initialBlank;
    if (bus_io.initialBlank == 5'd0 || bus_io.initialBlank > 5'd16) begin
      load_blank = 5'd16;
    end
  end

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    from_d  = from_q;
    to_d    = to_q;
    vld_d   = 1'b0;
    rej_d   = 1'b0;
    cnt_d   = cnt_q;

    if (bus_io.load) begin
      state_d = S_IDLE;
      blank_d = load_blank;
      from_d  = load_blank;
      to_d    = load_blank;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.dirValid) begin
            if (legal) begin
              state_d = S_MOVE;
              from_d  = nbr;
              to_d    = blank_q;
              vld_d   = 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        S_MOVE: begin
          // from_q still holds the neighbour; it becomes the new blank.
          state_d = S_SETTLE;
          blank_d = from_q;
          to_d    = from_q;
          if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          state_d = bus_io.ifWin ? S_WON : S_IDLE;
        end
        S_WON: begin
          state_d = S_WON;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_IDLE;
      blank_q <= BLANK_RST;
      from_q  <= BLANK_RST;
      to_q    <= BLANK_RST;
      vld_q   <= 1'b0;
      rej_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      from_q  <= from_d;
      to_q    <= to_d;
      vld_q   <= vld_d;
      rej_q   <= rej_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.moveFrom  = from_q;
  assign bus_io.moveTo    = to_q;
  assign bus_io.moveValid = vld_q;
  assign bus_io.reject    = rej_q;
  assign bus_io.ready     = (state_q == S_IDLE);
  assign bus_io.won       = (state_q == S_WON);
  assign bus_io.moveCount = cnt_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: stimulus pushes expected move/reject events,
// a negedge monitor pops and compares them; the stimulus thread checks state between events.
module tb_move_controller;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  move_controller_if #(.COUNT_WIDTH(14)) bus();

  move_controller #(
    .COUNT_WIDTH(14),
    .MAX_MOVES  (9999),
    .RESET_BLANK(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus_io(bus)
  );

  typedef struct packed {
    logic        is_move;
    logic [4:0]  from;
    logic [4:0]  to;
    logic [13:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   mdl_blank;
  int   mdl_cnt;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every moveValid/reject pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!resetn && (bus.moveValid || bus.reject)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus.moveValid, bus.reject}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_valid",  bus.moveValid, mon_e.is_move);
        check("evt_reject", bus.reject,    !mon_e.is_move);
        check("evt_from",   bus.moveFrom,  mon_e.from);
        check("evt_to",     bus.moveTo,    mon_e.to);
        check("evt_cnt",    bus.moveCount, mon_e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input int expb);
    tick();
    bus.load         = 1'b1;
    bus.initialBlank = 5'(v);
    tick();
    bus.load = 1'b0;
    check("load_from",  bus.moveFrom,  expb);
    check("load_to",    bus.moveTo,    expb);
    check("load_cnt",   bus.moveCount, 0);
    check("load_ready", bus.ready,     1);
    check("load_won",   bus.won,       0);
    mdl_blank = expb;
    mdl_cnt   = 0;
  endtask

  task automatic do_cmd(input logic [1:0] d, input bit legal, input int n, input bit full);
    exp_t e;
    e.is_move = legal;
    e.from    = 5'(legal ? n : mdl_blank);
    e.to      = 5'(mdl_blank);
    e.cnt     = 14'(mdl_cnt);
    exp_q.push_back(e);
    tick();
    bus.dirValid = 1'b1;
    bus.dir      = d;
    tick();
    bus.dirValid = 1'b0;
    if (legal) begin
      if (full) check("move_ready", bus.ready, 0);
      tick();
      mdl_blank = n;
      if (mdl_cnt < 9999) mdl_cnt++;
      if (full) begin
        check("settle_from",  bus.moveFrom,  n);
        check("settle_to",    bus.moveTo,    n);
        check("settle_valid", bus.moveValid, 0);
        check("settle_cnt",   bus.moveCount, mdl_cnt);
        check("settle_ready", bus.ready,     0);
      end
      tick();
      if (full) begin
        check("after_ready", bus.ready, bus.ifWin ? 0 : 1);
        check("after_won",   bus.won,   bus.ifWin ? 1 : 0);
      end
    end else if (full) begin
      check("rej_ready", bus.ready,     1);
      check("rej_from",  bus.moveFrom,  mdl_blank);
      check("rej_to",    bus.moveTo,    mdl_blank);
      check("rej_cnt",   bus.moveCount, mdl_cnt);
    end
  endtask

  initial begin
    resetn           = 1'b1;
    bus.load         = 1'b0;
    bus.initialBlank = 5'd0;
    bus.dirValid     = 1'b0;
    bus.dir          = 2'd0;
    bus.ifWin        = 1'b0;
    mdl_blank        = 16;
    mdl_cnt          = 0;
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    check("rst_ready", bus.ready,     1);
    check("rst_from",  bus.moveFrom,  16);
    check("rst_to",    bus.moveTo,    16);
    check("rst_valid", bus.moveValid, 0);
    check("rst_rej",   bus.reject,    0);
    check("rst_won",   bus.won,       0);
    check("rst_cnt",   bus.moveCount, 0);

    // Basic reject and accept from the corner.
    do_load(16, 16);
    do_cmd(UP,   1'b0, 0,  1'b1);
    do_cmd(DOWN, 1'b1, 12, 1'b1);

    // Edge legality.
    do_load(4, 4);
    do_cmd(LEFT, 1'b0, 0, 1'b1);
    do_cmd(UP,   1'b1, 8, 1'b1);
    do_load(5, 5);
    do_cmd(RIGHT, 1'b0, 0, 1'b1);
    do_cmd(LEFT,  1'b1, 6, 1'b1);
    do_cmd(RIGHT, 1'b1, 5, 1'b1);

    // Out-of-range initial blanks.
    do_load(0, 16);
    do_load(20, 16);

    // dirValid held through MOVE and SETTLE must be dropped.
    begin
      exp_t e;
      e.is_move = 1'b1;
      e.from    = 5'd12;
      e.to      = 5'd16;
      e.cnt     = 14'd0;
      exp_q.push_back(e);
    end
    tick();
    bus.dirValid = 1'b1;
    bus.dir      = DOWN;
    tick();
    bus.dir = UP;
    tick();
    bus.dir = DOWN;
    tick();
    bus.dirValid = 1'b0;
    mdl_blank = 12;
    mdl_cnt   = 1;
    check("drop_cnt",   bus.moveCount, 1);
    check("drop_from",  bus.moveFrom,  12);
    check("drop_ready", bus.ready,     1);
    repeat (3) tick();

    // Win path and lockout.
    bus.ifWin = 1'b1;
    do_cmd(DOWN, 1'b1, 8, 1'b1);
    repeat (2) begin
      tick();
      bus.dirValid = 1'b1;
      bus.dir      = UP;
      tick();
      bus.dirValid = 1'b0;
    end
    tick();
    check("won_hold",  bus.won,       1);
    check("won_ready", bus.ready,     0);
    check("won_from",  bus.moveFrom,  8);
    check("won_to",    bus.moveTo,    8);
    check("won_cnt",   bus.moveCount, 2);
    bus.ifWin = 1'b0;
    do_load(7, 7);

    // Async reset in the middle of a move.
    do_load(4, 4);
    do_cmd(UP, 1'b1, 8, 1'b1);
    tick();
    bus.dirValid = 1'b1;
    bus.dir      = DOWN;
    tick();
    bus.dirValid = 1'b0;
    check("pre_rst_valid", bus.moveValid, 1);
    #2;
    resetn = 1'b1;
    #1;
    check("arst_valid", bus.moveValid, 0);
    check("arst_from",  bus.moveFrom,  16);
    check("arst_to",    bus.moveTo,    16);
    check("arst_cnt",   bus.moveCount, 0);
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    check("arst_ready", bus.ready,    1);
    check("arst_from2", bus.moveFrom, 16);
    mdl_blank = 16;
    mdl_cnt   = 0;

    // Saturation: walk the count up to 9997, then three checked moves.
    do_load(16, 16);
    for (int i = 0; i < 9997; i++) begin
      if (mdl_blank == 16) do_cmd(DOWN, 1'b1, 12, 1'b0);
      else                 do_cmd(UP,   1'b1, 16, 1'b0);
    end
    check("sat_pre", bus.moveCount, 9997);
    for (int i = 0; i < 3; i++) begin
      if (mdl_blank == 16) do_cmd(DOWN, 1'b1, 12, 1'b1);
      else                 do_cmd(UP,   1'b1, 16, 1'b1);
    end
    check("sat_final", bus.moveCount, 9999);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
